// File: rtl/sky130_sram_req_adapter_if.sv
// rtl/sky130_sram_req_adapter_if.sv - request/response bus between a client and the SRAM adapter
interface sky130_sram_req_adapter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = 8
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_WMASKS-1:0] req_be_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;

  // Adapter side
  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_be_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  // Client side
  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_be_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );
endinterface

// File: rtl/sky130_sram_req_adapter.sv
// rtl/sky130_sram_req_adapter.sv - valid/ready request front end for a sky130 single-port SRAM macro
module sky130_sram_req_adapter #(
  parameter int DATA_WIDTH       = 64,
  parameter int ADDR_WIDTH       = 9,
  parameter int MACRO_ADDR_WIDTH = 10,
  parameter int NUM_WMASKS       = 8,
  parameter int RSP_DEPTH        = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  sky130_sram_req_adapter_if.slave    bus,
  output logic                        csb0_o,
  output logic                        web0_o,
  output logic [NUM_WMASKS-1:0]       wmask0_o,
  output logic                        spare_wen0_o,
  output logic [MACRO_ADDR_WIDTH-1:0] addr0_o,
  output logic [DATA_WIDTH-1:0]       din0_o,
  input  logic [DATA_WIDTH-1:0]       dout0_i
);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [CNT_W-1:0]      credit_cnt;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic                  stage1_q;
  logic                  stage2_q;
  logic                  accept;
  logic                  rd_accept;
  logic                  push;
  logic                  pop;

  // A read holds a credit from acceptance until its response is popped, so
  // the FIFO can never be asked to take more than it holds.
  assign bus.req_ready_o = credit_cnt < CNT_W'(RSP_DEPTH);
  assign accept          = bus.req_valid_i & bus.req_ready_o;
  assign rd_accept       = accept & ~bus.req_we_i;
  assign push            = stage2_q;
  assign pop             = bus.rsp_valid_o & bus.rsp_ready_i;
  assign bus.rsp_valid_o = fifo_cnt != '0;
  assign bus.rsp_rdata_o = fifo_mem[rd_ptr];
  assign spare_wen0_o    = 1'b0;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Outstanding-read credit counter; simultaneous accept and pop cancel out
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_cnt <= '0;
    end else if (rd_accept && !pop) begin
      credit_cnt <= credit_cnt + CNT_W'(1);
    end else if (!rd_accept && pop) begin
      credit_cnt <= credit_cnt - CNT_W'(1);
    end
  end

  // Macro command registers; idle cycles deselect but keep address/data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csb0_o   <= 1'b1;
      web0_o   <= 1'b1;
      wmask0_o <= '0;
      addr0_o  <= '0;
      din0_o   <= '0;
    end else if (accept) begin
      csb0_o   <= 1'b0;
      web0_o   <= ~bus.req_we_i;
      wmask0_o <= bus.req_we_i ? bus.req_be_i : '1;
      addr0_o  <= MACRO_ADDR_WIDTH'(bus.req_addr_i);
      din0_o   <= bus.req_wdata_i;
    end else begin
      csb0_o   <= 1'b1;
      web0_o   <= 1'b1;
      wmask0_o <= '0;
    end
  end

  // Read tags follow the macro pipeline: command issue, then data on dout0_i
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage1_q <= 1'b0;
      stage2_q <= 1'b0;
    end else begin
      stage1_q <= rd_accept;
      stage2_q <= stage1_q;
    end
  end

  // Response FIFO; push and pop on a full FIFO touch the same slot safely
  // because the head is read out before the edge overwrites it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= dout0_i;
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CNT_W'(1);
      end else if (!push && pop) begin
        fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_sky130_sram_req_adapter.sv
// tb/tb_sky130_sram_req_adapter.sv - randomized self-checking bench with transaction-level model
module tb_sky130_sram_req_adapter;
  localparam int DW    = 64;
  localparam int AW    = 9;
  localparam int MAW   = 10;
  localparam int NW    = 8;
  localparam int DEPTH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sky130_sram_req_adapter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NW)) bus ();

  logic           csb0, web0, spare_wen0;
  logic [NW-1:0]  wmask0;
  logic [MAW-1:0] addr0;
  logic [DW-1:0]  din0;
  logic [DW-1:0]  dout0;

  sky130_sram_req_adapter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MACRO_ADDR_WIDTH(MAW),
    .NUM_WMASKS(NW), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .csb0_o(csb0), .web0_o(web0), .wmask0_o(wmask0), .spare_wen0_o(spare_wen0),
    .addr0_o(addr0), .din0_o(din0), .dout0_i(dout0)
  );

  // Macro model: command captured at the edge, read data presented after it
  logic [DW-1:0] sram [1024];
  logic [DW-1:0] sram_w;
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        sram_w = sram[addr0];
        for (int b = 0; b < NW; b++) begin
          if (wmask0[b]) sram_w[b*8 +: 8] = din0[b*8 +: 8];
        end
        sram[addr0] <= sram_w;
      end else begin
        dout0 <= sram[addr0];
      end
    end
  end

  // Reference model: word memory, in-flight reads with due cycle, response queue
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } infl_t;

  logic [DW-1:0] refmem [512];
  infl_t         inflight [$];
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] got [$];
  int            cyc;
  logic          e_csb, e_web;
  logic [NW-1:0] e_wmask;
  logic [MAW-1:0] e_addr;
  logic [DW-1:0] e_din;
  logic          last_acc;
  int            n_cmp;
  int            n_fail;
  int            acc_cnt;

  function automatic logic m_ready();
    return (inflight.size() + fifo_q.size()) < DEPTH;
  endfunction

  task automatic m_reset();
    inflight.delete();
    fifo_q.delete();
    e_csb = 1'b1; e_web = 1'b1; e_wmask = '0; e_addr = '0; e_din = '0;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("req_ready", DW'(bus.req_ready_o), DW'(m_ready()));
    chk("rsp_valid", DW'(bus.rsp_valid_o), DW'(fifo_q.size() > 0));
    if (fifo_q.size() > 0) chk("rsp_rdata", bus.rsp_rdata_o, fifo_q[0]);
    chk("csb0", DW'(csb0), DW'(e_csb));
    chk("web0", DW'(web0), DW'(e_web));
    chk("wmask0", DW'(wmask0), DW'(e_wmask));
    chk("addr0", DW'(addr0), DW'(e_addr));
    chk("din0", din0, e_din);
    chk("spare_wen0", DW'(spare_wen0), '0);
  endtask

  // One clock cycle: drive at the falling edge, update the model at the
  // rising edge, compare at the next falling edge
  task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [NW-1:0] be, input logic [DW-1:0] wd, input logic rdy);
    logic acc, pop;
    logic [DW-1:0] w;
    bus.req_valid_i = v;
    bus.req_we_i    = we;
    bus.req_addr_i  = a;
    bus.req_be_i    = be;
    bus.req_wdata_i = wd;
    bus.rsp_ready_i = rdy;
    acc = v && m_ready();
    pop = rdy && (fifo_q.size() > 0);
    if (pop) got.push_back(bus.rsp_rdata_o);
    @(posedge clk);
    cyc++;
    if (pop) void'(fifo_q.pop_front());
    while (inflight.size() > 0 && inflight[0].due == cyc) begin
      fifo_q.push_back(inflight[0].data);
      void'(inflight.pop_front());
    end
    if (acc) begin
      e_csb = 1'b0; e_web = !we; e_wmask = we ? be : '1;
      e_addr = {1'b0, a}; e_din = wd;
      if (we) begin
        w = refmem[a];
        for (int b = 0; b < NW; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
        refmem[a] = w;
      end else begin
        inflight.push_back('{refmem[a], cyc + 2});
      end
    end else begin
      e_csb = 1'b1; e_web = 1'b1; e_wmask = '0;
    end
    last_acc = acc;
    if (acc) acc_cnt++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, '0, '0, '0, rdy);
  endtask

  task automatic read_held(input logic [AW-1:0] a);
    int n;
    n = 0;
    do begin
      step(1'b1, 1'b0, a, '0, '0, 1'b1);
      n++;
    end while (!last_acc && n < 20);
    chk("read_accept_bound", DW'(last_acc), DW'(1'b1));
  endtask

  // Called at a falling edge; holds reset for two rising edges
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    m_reset();
    #1;
    chk("rst_csb0", DW'(csb0), DW'(1'b1));
    chk("rst_web0", DW'(web0), DW'(1'b1));
    chk("rst_wmask0", DW'(wmask0), '0);
    chk("rst_addr0", DW'(addr0), '0);
    chk("rst_din0", din0, '0);
    chk("rst_rsp_valid", DW'(bus.rsp_valid_o), '0);
    chk("rst_rsp_rdata", bus.rsp_rdata_o, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", DW'(bus.req_ready_o), DW'(1'b1));
  endtask

  initial begin
    logic [DW-1:0] v;
    n_cmp = 0; n_fail = 0; cyc = 0; acc_cnt = 0; last_acc = 1'b0;
    dout0 = '0;
    for (int i = 0; i < 1024; i++) sram[i] = '0;
    for (int i = 0; i < 512; i++) begin
      v = {$urandom, $urandom};
      refmem[i] = v;
      sram[i] = v;
    end
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0;
    bus.req_be_i = '0; bus.req_wdata_i = '0; bus.rsp_ready_i = 1'b0;
    m_reset();
    @(negedge clk);
    do_reset();

    // Full write then read back with 2-cycle latency
    step(1'b1, 1'b1, 9'h005, 8'hFF, 64'hDEADBEEF_01234567, 1'b1);
    chk("w_wmask_ff", DW'(wmask0), DW'(8'hFF));
    chk("w_addr_005", DW'(addr0), DW'(10'h005));
    chk("w_web_low", DW'(web0), '0);
    step(1'b1, 1'b0, 9'h005, 8'h00, '0, 1'b1);
    chk("r_wmask_ones", DW'(wmask0), DW'(8'hFF));
    idle(1'b1);
    chk("lat1_not_valid", DW'(bus.rsp_valid_o), '0);
    idle(1'b1);
    chk("lat2_valid", DW'(bus.rsp_valid_o), DW'(1'b1));
    chk("lat2_rdata", bus.rsp_rdata_o, 64'hDEADBEEF_01234567);
    idle(1'b1);

    // Partial write over 0xAA pattern at the top address
    step(1'b1, 1'b1, 9'h1FF, 8'hFF, {8{8'hAA}}, 1'b1);
    step(1'b1, 1'b1, 9'h1FF, 8'h0F, 64'h11223344_55667788, 1'b1);
    chk("top_addr0", DW'(addr0), DW'(10'h1FF));
    chk("part_wmask", DW'(wmask0), DW'(8'h0F));
    step(1'b1, 1'b0, 9'h1FF, 8'h00, '0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("part_rdata", bus.rsp_rdata_o, 64'hAAAAAAAA_55667788);
    idle(1'b1);

    // Zero-byte-enable write is still issued
    step(1'b1, 1'b1, 9'h010, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b1);
    chk("be0_csb", DW'(csb0), '0);
    chk("be0_wmask", DW'(wmask0), '0);
    repeat (3) idle(1'b1);

    // Back-to-back reads, in-order responses
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, AW'(i), 8'hFF, DW'(64'h100 + i), 1'b1);
    got.delete();
    for (int i = 0; i < 5; i++) read_held(AW'(i));
    repeat (5) idle(1'b1);
    chk("b2b_count", DW'(got.size()), DW'(5));
    for (int i = 0; i < 5 && i < got.size(); i++) chk("b2b_data", got[i], DW'(64'h100 + i));

    // Credit limit with a stalled consumer
    got.delete();
    acc_cnt = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, AW'(i), '0, '0, 1'b0);
    chk("stall_accepts", DW'(acc_cnt), DW'(3));
    chk("stall_ready_low", DW'(bus.req_ready_o), '0);
    idle(1'b1);
    chk("ready_after_pop", DW'(bus.req_ready_o), DW'(1'b1));
    read_held(AW'(3));
    repeat (6) idle(1'b1);
    chk("stall_count", DW'(got.size()), DW'(4));
    for (int i = 0; i < 4 && i < got.size(); i++) chk("stall_data", got[i], DW'(64'h100 + i));

    // Reset right after a read accept discards it
    step(1'b1, 1'b0, 9'h007, '0, '0, 1'b1);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      chk("no_stale_rsp", DW'(bus.rsp_valid_o), '0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      step($urandom_range(0, 3) != 0, 1'($urandom), a, NW'($urandom),
           {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      if (i == 1500) do_reset();
    end
    repeat (10) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
